// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and types for the timer interrupt controller
package timer_pkg;

   // Register addresses
   localparam int unsigned ADDR_IER  = 0;
   localparam int unsigned ADDR_IPR  = 1;
   localparam int unsigned ADDR_ICNT = 2;
   localparam int unsigned ADDR_ICFG = 3;

   // Flag bit positions in IER/IPR
   localparam int unsigned BIT_OVF = 0;
   localparam int unsigned BIT_UDF = 1;

   // APB phase tracker
   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_SETUP  = 2'd1,
      APB_ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/timer_irq_edge.sv
// rtl/timer_irq_edge.sv - registered rising-edge detector for one timer flag
module timer_irq_edge (
   input  logic pclk,
   input  logic presetn,
   input  logic lvl,
   output logic evt
);

   logic lvl_q;
   logic lvl_d;

   // Next value of the delayed flag is simply the current level
   always_comb begin
      lvl_d = lvl;
   end

   // Delay flop; reset to 0 so a flag already high at reset release is an event
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) lvl_q <= 1'b0;
      else          lvl_q <= lvl_d;
   end

   assign evt = lvl & ~lvl_q;

endmodule

// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - maskable interrupt controller for timer overflow/underflow flags
module timer_irq_ctrl
   import timer_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic              tmr_ovf,
   input  logic              tmr_udf,
   output logic              irq
);

   logic       ovf_evt, udf_evt;
   logic [1:0] evt;
   logic       access, addr_err, wr_en;
   logic       sel_ier, sel_ipr, sel_icnt, sel_icfg;
   logic [1:0] ier_q, ier_d;
   logic [1:0] ipr_q, ipr_d;
   logic [1:0] rose_q, rose_d;
   logic [7:0] icnt_q, icnt_d;
   logic [7:0] icnt_base;
   logic [8:0] icnt_sum;
   logic       mode_q, mode_d;
   logic       irq_q, irq_d;
   apb_state_e state_q, state_d;
   logic       unused_wdata;

   timer_irq_edge u_edge_ovf (.pclk(pclk), .presetn(presetn), .lvl(tmr_ovf), .evt(ovf_evt));
   timer_irq_edge u_edge_udf (.pclk(pclk), .presetn(presetn), .lvl(tmr_udf), .evt(udf_evt));

   assign evt[BIT_OVF] = ovf_evt;
   assign evt[BIT_UDF] = udf_evt;

   assign access   = psel & penable;
   assign addr_err = access & (paddr > ADDR_W'(ADDR_ICFG));
   assign wr_en    = access & pwrite & ~addr_err;
   assign sel_ier  = (paddr == ADDR_W'(ADDR_IER));
   assign sel_ipr  = (paddr == ADDR_W'(ADDR_IPR));
   assign sel_icnt = (paddr == ADDR_W'(ADDR_ICNT));
   assign sel_icfg = (paddr == ADDR_W'(ADDR_ICFG));

   assign pready       = 1'b1;
   assign pslverr      = addr_err;
   assign irq          = irq_q;
   assign unused_wdata = ^pwdata[DATA_W-1:2];

   // Register file next-state: writes first, then events so a same-cycle set beats a clear
   always_comb begin
      ier_d  = ier_q;
      mode_d = mode_q;
      ipr_d  = ipr_q;
      if (wr_en && sel_ier)  ier_d  = pwdata[1:0];
      if (wr_en && sel_icfg) mode_d = pwdata[0];
      if (wr_en && sel_ipr)  ipr_d  = ipr_q & pwdata[1:0];
      ipr_d  = ipr_d | evt;
      rose_d = ipr_d & ~ipr_q;
   end

   // Event counter: a same-cycle clear still keeps this cycle's events; saturates at 0xFF
   always_comb begin
      icnt_base = (wr_en && sel_icnt) ? 8'h00 : icnt_q;
      icnt_sum  = {1'b0, icnt_base} + {7'd0, evt[BIT_OVF]} + {7'd0, evt[BIT_UDF]};
      icnt_d    = icnt_sum[8] ? 8'hFF : icnt_sum[7:0];
   end

   // Interrupt: level follows enabled pending bits, pulse follows newly set enabled bits
   always_comb begin
      irq_d = mode_q ? |(rose_q & ier_q) : |(ipr_q & ier_q);
   end

   // APB phase tracker, kept only for protocol checking
   always_comb begin
      if (psel && !penable)     state_d = APB_SETUP;
      else if (psel && penable) state_d = APB_ACCESS;
      else                      state_d = APB_IDLE;
   end

   // Read mux, live only during a mapped access phase
   always_comb begin
      prdata = '0;
      if (access && !addr_err) begin
         if (sel_ier)       prdata = DATA_W'(ier_q);
         else if (sel_ipr)  prdata = DATA_W'(ipr_q);
         else if (sel_icnt) prdata = DATA_W'(icnt_q);
         else if (sel_icfg) prdata = DATA_W'(mode_q);
      end
   end

   // State flops
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         ier_q   <= '0;
         ipr_q   <= '0;
         rose_q  <= '0;
         icnt_q  <= '0;
         mode_q  <= 1'b0;
         irq_q   <= 1'b0;
         state_q <= APB_IDLE;
      end else begin
         ier_q   <= ier_d;
         ipr_q   <= ipr_d;
         rose_q  <= rose_d;
         icnt_q  <= icnt_d;
         mode_q  <= mode_d;
         irq_q   <= irq_d;
         state_q <= state_d;
      end
   end

   // An access phase must come straight after a setup phase
   property p_access_after_setup;
      @(posedge pclk) disable iff (!presetn) (psel && penable) |-> (state_q == APB_SETUP);
   endproperty
   assert property (p_access_after_setup);

endmodule
